// File: rtl/universal_shift_register_if.sv
// Bundle of data/control signals for universal_shift_register.
// master drives en/mode/serial/parallel inputs; slave is the register side.
interface universal_shift_register_if #(
    parameter int WIDTH = 8
) ();
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             en;
    logic [1:0]       mode;
    logic             serial_in_r;
    logic             serial_in_l;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out_r;
    logic             serial_out_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             frame_done;

    modport master (
        output en, mode, serial_in_r, serial_in_l, parallel_in,
        input  parallel_out, serial_out_r, serial_out_l,
        input  shift_cnt, frame_done
    );

    modport slave (
        input  en, mode, serial_in_r, serial_in_l, parallel_in,
        output parallel_out, serial_out_r, serial_out_l,
        output shift_cnt, frame_done
    );
endinterface

// File: rtl/universal_shift_register.sv
// Universal shift register: hold / shift right / shift left / load,
// with a shift counter pulsing frame_done on every WIDTH-th shift.
// Ports: clk, reset_n (async active-low), bus (slave modport):
//   en, mode, serial_in_r/l, parallel_in -> parallel_out,
//   serial_out_r/l, shift_cnt, frame_done.
module universal_shift_register #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic reset_n,
    universal_shift_register_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fd_q, fd_d;
    logic             shift;

    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        fd_d  = 1'b0;
        shift = 1'b0;
        if (bus.en) begin
            unique case (bus.mode)
                2'b01: begin
                    q_d   = {bus.serial_in_r, q_q[WIDTH-1:1]};
                    shift = 1'b1;
                end
                2'b10: begin
                    q_d   = {q_q[WIDTH-2:0], bus.serial_in_l};
                    shift = 1'b1;
                end
                2'b11: begin
                    q_d   = bus.parallel_in;
                    cnt_d = '0;
                end
                default: ;
            endcase
        end
        // Both directions share one counter so mixed shifts accumulate.
        if (shift) begin
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                cnt_d = '0;
                fd_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q   <= '0;
            cnt_q <= '0;
            fd_q  <= 1'b0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
            fd_q  <= fd_d;
        end
    end

    assign bus.parallel_out = q_q;
    assign bus.serial_out_r = q_q[0];
    assign bus.serial_out_l = q_q[WIDTH-1];
    assign bus.shift_cnt    = cnt_q;
    assign bus.frame_done   = fd_q;
endmodule
